// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit sequencer for the E stage, owner of HI/LO.
// A multi-cycle op computes its result at issue, parks it in pend_hi/pend_lo,
// then a down-counter models the unit latency before HI/LO commit.
// Optional feature macro: MDU_MADD_EN (op 6 = madd, accumulates into HI/LO).
//
// state | meaning
// IDLE  | accepting mult/multu/div/divu/mthi/mtlo (and madd when enabled)
// BUSY  | counting down latency; commits pending result when cnt reaches 1
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_keep_q, pend_keep_d;
  logic        done_q, done_d;
`ifdef MDU_MADD_EN
  logic        pend_acc_q, pend_acc_d;
  logic [63:0] acc_sum;
`endif

  logic [63:0] prod_s, prod_u;
  logic [31:0] rs_mag, rt_mag, dvs_s, dvs_u;
  logic [31:0] sq_mag, sr_mag, quo_s, rem_s, quo_u, rem_u;
  logic        rt_zero, start_multi;

  // Operand arithmetic for all result types, evaluated every cycle from the forwarded operands
  always_comb begin
    // Low 64 bits of a product of sign-extended operands equal the signed product.
    prod_s  = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
    rt_zero = (rt_val == 32'd0);
    // Signed divide on magnitudes keeps INT_MIN/-1 well defined (quotient wraps to INT_MIN).
    rs_mag  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    rt_mag  = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    dvs_s   = rt_zero ? 32'd1 : rt_mag;
    dvs_u   = rt_zero ? 32'd1 : rt_val;
    sq_mag  = rs_mag / dvs_s;
    sr_mag  = rs_mag % dvs_s;
    quo_s   = (rs_val[31] ^ rt_val[31]) ? (32'd0 - sq_mag) : sq_mag;
    rem_s   = rs_val[31] ? (32'd0 - sr_mag) : sr_mag;
    quo_u   = rs_val / dvs_u;
    rem_u   = rs_val % dvs_u;
`ifdef MDU_MADD_EN
    acc_sum = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
`endif
  end

  // Issue-cycle stall term covers ops that will occupy the unit
  always_comb begin
    start_multi = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                  (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
    if (md_op == OP_MADD) start_multi = 1'b1;
`endif
    stall_req = md_use_D & ((state_q == BUSY) | (md_start & start_multi));
  end

  // Next-state, counter, pending-result and HI/LO update logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_keep_d = pend_keep_q;
    done_d      = 1'b0;
`ifdef MDU_MADD_EN
    pend_acc_d  = pend_acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_keep_d = 1'b0;
`ifdef MDU_MADD_EN
              pend_acc_d  = 1'b0;
`endif
              cnt_d   = MULT_LOAD;
              state_d = BUSY;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_keep_d = 1'b0;
`ifdef MDU_MADD_EN
              pend_acc_d  = 1'b0;
`endif
              cnt_d   = MULT_LOAD;
              state_d = BUSY;
            end
            OP_DIV: begin
              pend_hi_d   = rem_s;
              pend_lo_d   = quo_s;
              pend_keep_d = rt_zero;
`ifdef MDU_MADD_EN
              pend_acc_d  = 1'b0;
`endif
              cnt_d   = DIV_LOAD;
              state_d = BUSY;
            end
            OP_DIVU: begin
              pend_hi_d   = rem_u;
              pend_lo_d   = quo_u;
              pend_keep_d = rt_zero;
`ifdef MDU_MADD_EN
              pend_acc_d  = 1'b0;
`endif
              cnt_d   = DIV_LOAD;
              state_d = BUSY;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_keep_d = 1'b0;
              pend_acc_d  = 1'b1;
              cnt_d   = MULT_LOAD;
              state_d = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        // A start here is a hazard-unit violation and is deliberately ignored.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (!pend_keep_q) begin
`ifdef MDU_MADD_EN
            if (pend_acc_q) begin
              {hi_d, lo_d} = acc_sum;
            end else begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
`else
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_keep_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef MDU_MADD_EN
      pend_acc_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_keep_q <= pend_keep_d;
      done_q      <= done_d;
`ifdef MDU_MADD_EN
      pend_acc_q  <= pend_acc_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == BUSY);
  assign done = done_q;

endmodule
